// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared widths and NOP constants for the ID/EX pipeline register.
// The NOP entry is all zeros so that a cleared entry never enables writeback.
package id_ex_pipe_reg_pkg;
  localparam int WORD_W    = 32;
  localparam int SHIFT_W   = 12;
  localparam int IMM24_W   = 24;
  localparam int EXE_CMD_W = 4;
  localparam int REG_IDX_W = 4;
  localparam int STATUS_W  = 4;
  localparam int CTRL_W    = 5;

  // Packed width of every data/index field carried from ID to EX.
  localparam int DATA_W = 3*WORD_W + SHIFT_W + IMM24_W + 1 + EXE_CMD_W + 3*REG_IDX_W + STATUS_W;

  localparam logic [EXE_CMD_W-1:0] EXE_CMD_NOP = 4'd0;
  localparam logic [REG_IDX_W-1:0] REG_IDX_NOP = 4'd0;
  localparam logic [STATUS_W-1:0]  STATUS_NOP  = 4'd0;
  localparam logic [CTRL_W-1:0]    CTRL_NOP    = 5'b00000;
  localparam logic [DATA_W-1:0]    DATA_NOP    = {DATA_W{1'b0}};
endpackage

// File: rtl/id_ex_pipe_reg_field.sv
// One group of pipeline fields: hold when en is low, load clr_val on clr,
// otherwise capture d. Async active-high reset returns the group to clr_val.
module pipe_field_reg #(
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] q_r;

  // Field register with hold / clear / load priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= CLR_VAL;
    end else if (en) begin
      if (clr) begin
        q_r <= CLR_VAL;
      end else begin
        q_r <= d;
      end
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;
endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with freeze, flush and bubble handling plus
// saturating counters of flushes and inserted bubbles.
module id_ex_pipe_reg
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              bubble,
  input  logic [31:0]       pc_in,
  input  logic [31:0]       val_rn_in,
  input  logic [31:0]       val_rm_in,
  input  logic [11:0]       shift_operand_in,
  input  logic [23:0]       signed_imm24_in,
  input  logic              imm_in,
  input  logic [3:0]        exe_cmd_in,
  input  logic [3:0]        dest_in,
  input  logic [3:0]        src1_in,
  input  logic [3:0]        src2_in,
  input  logic [3:0]        status_in,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic              s_in,
  input  logic              b_in,
  output logic [31:0]       pc_out,
  output logic [31:0]       val_rn_out,
  output logic [31:0]       val_rm_out,
  output logic [11:0]       shift_operand_out,
  output logic [23:0]       signed_imm24_out,
  output logic              imm_out,
  output logic [3:0]        exe_cmd_out,
  output logic [3:0]        dest_out,
  output logic [3:0]        src1_out,
  output logic [3:0]        src2_out,
  output logic [3:0]        status_out,
  output logic              wb_en_out,
  output logic              mem_r_en_out,
  output logic              mem_w_en_out,
  output logic              s_out,
  output logic              b_out,
  output logic              valid_out,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  logic              load_en_s;
  logic              clr_s;
  logic [DATA_W-1:0] data_d_s;
  logic [DATA_W-1:0] data_q_s;
  logic [CTRL_W-1:0] ctrl_d_s;
  logic [CTRL_W-1:0] ctrl_q_s;
  logic [CNT_W-1:0]  bubble_cnt_r;
  logic [CNT_W-1:0]  flush_cnt_r;

  // freeze overrides everything; flush and bubble clear identically.
  assign load_en_s = ~freeze;
  assign clr_s     = flush | bubble;

  assign data_d_s = {pc_in, val_rn_in, val_rm_in, shift_operand_in, signed_imm24_in,
                     imm_in, exe_cmd_in, dest_in, src1_in, src2_in, status_in};
  assign ctrl_d_s = {wb_en_in, mem_r_en_in, mem_w_en_in, s_in, b_in};

  pipe_field_reg #(.WIDTH(DATA_W), .CLR_VAL(DATA_NOP)) u_data_reg (
    .clk(clk), .rst(rst), .en(load_en_s), .clr(clr_s), .d(data_d_s), .q(data_q_s)
  );

  pipe_field_reg #(.WIDTH(CTRL_W), .CLR_VAL(CTRL_NOP)) u_ctrl_reg (
    .clk(clk), .rst(rst), .en(load_en_s), .clr(clr_s), .d(ctrl_d_s), .q(ctrl_q_s)
  );

  pipe_field_reg #(.WIDTH(1), .CLR_VAL(1'b0)) u_valid_reg (
    .clk(clk), .rst(rst), .en(load_en_s), .clr(clr_s), .d(1'b1), .q(valid_out)
  );

  assign {pc_out, val_rn_out, val_rm_out, shift_operand_out, signed_imm24_out,
          imm_out, exe_cmd_out, dest_out, src1_out, src2_out, status_out} = data_q_s;
  assign {wb_en_out, mem_r_en_out, mem_w_en_out, s_out, b_out} = ctrl_q_s;

  // Saturating event counters; flush takes precedence when both are raised.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt_r  <= {CNT_W{1'b0}};
      bubble_cnt_r <= {CNT_W{1'b0}};
    end else if (!freeze) begin
      if (flush) begin
        if (flush_cnt_r != {CNT_W{1'b1}}) begin
          flush_cnt_r <= flush_cnt_r + CNT_W'(1'b1);
        end else begin
          flush_cnt_r <= flush_cnt_r;
        end
      end else if (bubble) begin
        if (bubble_cnt_r != {CNT_W{1'b1}}) begin
          bubble_cnt_r <= bubble_cnt_r + CNT_W'(1'b1);
        end else begin
          bubble_cnt_r <= bubble_cnt_r;
        end
      end else begin
        flush_cnt_r  <= flush_cnt_r;
        bubble_cnt_r <= bubble_cnt_r;
      end
    end else begin
      flush_cnt_r  <= flush_cnt_r;
      bubble_cnt_r <= bubble_cnt_r;
    end
  end

  assign bubble_cnt = bubble_cnt_r;
  assign flush_cnt  = flush_cnt_r;
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg built with 4-bit counters so that
// saturation is reachable in a handful of cycles.
module tb_id_ex_pipe_reg;
  logic        clk = 1'b0;
  logic        rst, freeze, flush, bubble;
  logic [31:0] pc_in, val_rn_in, val_rm_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm24_in;
  logic        imm_in;
  logic [3:0]  exe_cmd_in, dest_in, src1_in, src2_in, status_in;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in, s_in, b_in;
  logic [31:0] pc_out, val_rn_out, val_rm_out;
  logic [11:0] shift_operand_out;
  logic [23:0] signed_imm24_out;
  logic        imm_out;
  logic [3:0]  exe_cmd_out, dest_out, src1_out, src2_out, status_out;
  logic        wb_en_out, mem_r_en_out, mem_w_en_out, s_out, b_out, valid_out;
  logic [3:0]  bubble_cnt, flush_cnt;
  logic [166:0] all_out;
  logic [4:0]   ctrl_out;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign ctrl_out = {wb_en_out, mem_r_en_out, mem_w_en_out, s_out, b_out};
  assign all_out  = {pc_out, val_rn_out, val_rm_out, shift_operand_out, signed_imm24_out,
                     imm_out, exe_cmd_out, dest_out, src1_out, src2_out, status_out,
                     ctrl_out, valid_out, bubble_cnt, flush_cnt};

  id_ex_pipe_reg #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .bubble(bubble),
    .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
    .shift_operand_in(shift_operand_in), .signed_imm24_in(signed_imm24_in),
    .imm_in(imm_in), .exe_cmd_in(exe_cmd_in), .dest_in(dest_in),
    .src1_in(src1_in), .src2_in(src2_in), .status_in(status_in),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .s_in(s_in), .b_in(b_in),
    .pc_out(pc_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
    .shift_operand_out(shift_operand_out), .signed_imm24_out(signed_imm24_out),
    .imm_out(imm_out), .exe_cmd_out(exe_cmd_out), .dest_out(dest_out),
    .src1_out(src1_out), .src2_out(src2_out), .status_out(status_out),
    .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
    .s_out(s_out), .b_out(b_out), .valid_out(valid_out),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  // Advance one rising edge and settle 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    freeze = 1'b0; flush = 1'b0; bubble = 1'b0;
    pc_in = 32'd0; val_rn_in = 32'd0; val_rm_in = 32'd0;
    shift_operand_in = 12'd0; signed_imm24_in = 24'd0; imm_in = 1'b0;
    exe_cmd_in = 4'd0; dest_in = 4'd0; src1_in = 4'd0; src2_in = 4'd0; status_in = 4'd0;
    wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0; s_in = 1'b0; b_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    pc_in = 32'hFFFF_FFFF; wb_en_in = 1'b1; dest_in = 4'd7;
    tick();
    total++;
    if (all_out !== 167'd0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", all_out);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_load();
    pc_in = 32'h0000_0104; val_rn_in = 32'hDEAD_BEEF; val_rm_in = 32'h1234_5678;
    shift_operand_in = 12'h0AB; signed_imm24_in = 24'h123456; imm_in = 1'b1;
    exe_cmd_in = 4'h2; dest_in = 4'd5; src1_in = 4'd3; src2_in = 4'd7; status_in = 4'hA;
    wb_en_in = 1'b1; s_in = 1'b1;
    tick();
    total++;
    if ({pc_out, val_rn_out, val_rm_out} !== {32'h0000_0104, 32'hDEAD_BEEF, 32'h1234_5678}) begin
      bad++; $display("FAIL load_words got=%h %h %h", pc_out, val_rn_out, val_rm_out);
    end
    total++;
    if ({shift_operand_out, signed_imm24_out, imm_out, exe_cmd_out, dest_out, src1_out, src2_out, status_out}
        !== {12'h0AB, 24'h123456, 1'b1, 4'h2, 4'd5, 4'd3, 4'd7, 4'hA}) begin
      bad++; $display("FAIL load_fields dest=%0d src1=%0d src2=%0d cmd=%h", dest_out, src1_out, src2_out, exe_cmd_out);
    end
    total++;
    if ({ctrl_out, valid_out} !== {5'b10010, 1'b1}) begin
      bad++; $display("FAIL load_ctrl got=%b want=100101", {ctrl_out, valid_out});
    end
    // Input change between edges must not reach the outputs.
    dest_in = 4'd11; val_rn_in = 32'h0;
    #2;
    total++;
    if ({dest_out, val_rn_out} !== {4'd5, 32'hDEAD_BEEF}) begin
      bad++; $display("FAIL no_comb_path dest=%0d val_rn=%h", dest_out, val_rn_out);
    end
  endtask

  task automatic test_freeze();
    dest_in = 4'd9; val_rn_in = 32'h0000_1234; wb_en_in = 1'b0; mem_w_en_in = 1'b1;
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    total++;
    if ({dest_out, val_rn_out, ctrl_out, valid_out} !== {4'd5, 32'hDEAD_BEEF, 5'b10010, 1'b1}) begin
      bad++; $display("FAIL freeze_hold dest=%0d val_rn=%h ctrl=%b valid=%b", dest_out, val_rn_out, ctrl_out, valid_out);
    end
    total++;
    if ({bubble_cnt, flush_cnt} !== 8'h00) begin
      bad++; $display("FAIL freeze_cnt got=%h want=00", {bubble_cnt, flush_cnt});
    end
    freeze = 1'b0;
  endtask

  task automatic test_bubble_flush();
    bubble = 1'b1;
    tick();
    total++;
    if ({ctrl_out, valid_out, dest_out, src1_out, src2_out, val_rn_out} !== 50'd0) begin
      bad++; $display("FAIL bubble_clear ctrl=%b valid=%b dest=%0d val_rn=%h", ctrl_out, valid_out, dest_out, val_rn_out);
    end
    total++;
    if ({bubble_cnt, flush_cnt} !== {4'd1, 4'd0}) begin
      bad++; $display("FAIL bubble_cnt got=%h want=10", {bubble_cnt, flush_cnt});
    end
    flush = 1'b1;
    tick();
    total++;
    if ({bubble_cnt, flush_cnt, valid_out} !== {4'd1, 4'd1, 1'b0}) begin
      bad++; $display("FAIL flush_wins got=%h want=110", {bubble_cnt, flush_cnt, valid_out});
    end
    clear_inputs();
  endtask

  task automatic test_freeze_over_flush();
    dest_in = 4'd6; wb_en_in = 1'b1; b_in = 1'b1;
    tick();
    freeze = 1'b1; flush = 1'b1;
    tick();
    total++;
    if ({dest_out, ctrl_out, valid_out, flush_cnt} !== {4'd6, 5'b10001, 1'b1, 4'd1}) begin
      bad++; $display("FAIL freeze_over_flush dest=%0d ctrl=%b valid=%b fcnt=%0d", dest_out, ctrl_out, valid_out, flush_cnt);
    end
    freeze = 1'b0;
    tick();
    total++;
    if ({dest_out, ctrl_out, valid_out, flush_cnt} !== {4'd0, 5'b00000, 1'b0, 4'd2}) begin
      bad++; $display("FAIL deferred_flush dest=%0d ctrl=%b valid=%b fcnt=%0d", dest_out, ctrl_out, valid_out, flush_cnt);
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    dest_in = 4'd1; src1_in = 4'd2; src2_in = 4'd3; mem_r_en_in = 1'b1; wb_en_in = 1'b1;
    pc_in = 32'h0000_0200;
    tick();
    dest_in = 4'd2; src1_in = 4'd4; src2_in = 4'd5; mem_r_en_in = 1'b0; wb_en_in = 1'b0;
    mem_w_en_in = 1'b1; pc_in = 32'h0000_0204;
    total++;
    if ({pc_out, dest_out, src1_out, src2_out, ctrl_out, valid_out} !== {32'h0000_0200, 4'd1, 4'd2, 4'd3, 5'b11000, 1'b1}) begin
      bad++; $display("FAIL b2b_first pc=%h dest=%0d ctrl=%b", pc_out, dest_out, ctrl_out);
    end
    tick();
    total++;
    if ({pc_out, dest_out, src1_out, src2_out, ctrl_out, valid_out} !== {32'h0000_0204, 4'd2, 4'd4, 4'd5, 5'b00100, 1'b1}) begin
      bad++; $display("FAIL b2b_second pc=%h dest=%0d ctrl=%b", pc_out, dest_out, ctrl_out);
    end
    clear_inputs();
  endtask

  task automatic test_saturation();
    bubble = 1'b1;
    for (int i = 0; i < 13; i++) tick();
    total++;
    if (bubble_cnt !== 4'hE) begin
      bad++; $display("FAIL bubble_cnt_14 got=%h want=e", bubble_cnt);
    end
    for (int i = 0; i < 7; i++) tick();
    total++;
    if ({bubble_cnt, flush_cnt} !== {4'hF, 4'd2}) begin
      bad++; $display("FAIL bubble_saturate got=%h want=f2", {bubble_cnt, flush_cnt});
    end
    clear_inputs();
  endtask

  task automatic test_async_reset();
    dest_in = 4'd8; wb_en_in = 1'b1; val_rm_in = 32'hCAFE_F00D;
    tick();
    total++;
    if ({dest_out, val_rm_out, valid_out} !== {4'd8, 32'hCAFE_F00D, 1'b1}) begin
      bad++; $display("FAIL pre_reset_load dest=%0d val_rm=%h", dest_out, val_rm_out);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (all_out !== 167'd0) begin
      bad++; $display("FAIL async_reset got=%h want=0", all_out);
    end
    #1 rst = 1'b0;
    tick();
    total++;
    if ({dest_out, valid_out, bubble_cnt, flush_cnt} !== {4'd8, 1'b1, 4'd0, 4'd0}) begin
      bad++; $display("FAIL post_reset_load dest=%0d valid=%b cnt=%h", dest_out, valid_out, {bubble_cnt, flush_cnt});
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_freeze();
    test_bubble_flush();
    test_freeze_over_flush();
    test_back_to_back();
    test_saturation();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
